if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the LA32R five-stage pipeline, directly upstream of the ID stage and its control-unit decoder.
- Owns the PC and issues requests to a synchronous instruction SRAM with 1-cycle read latency.
- Buffers returned instructions in a 2-entry bypassing FIFO and hands {pc, inst} to ID over a valid/allowin handshake.
- Accepts branch/jump redirects resolved downstream and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h1C00_0000, PC value loaded on reset.

Ports:
cpu_clk  input  1  clock; all state updates on rising edge.
cpu_rstn  input  1  reset, asynchronous, active-low.
inst_req  output  1  SRAM read request this cycle.
inst_addr  output  32  SRAM word address (byte address, [1:0]=0); equals pc_q.
inst_rdata  input  32  SRAM data, valid the cycle after an accepted request.
br_taken  input  1  redirect strobe from downstream branch resolution.
br_target  input  32  redirect target; [1:0] ignored.
id_allowin  input  1  ID can accept an instruction this cycle.
if_valid  output  1  if_pc/if_inst hold a valid instruction.
if_pc  output  32  PC of the presented instruction; 0 when if_valid=0.
if_inst  output  32  presented instruction; 0 when if_valid=0.

Behaviour:
- State: pc_q[31:0], inflight_q (1 b), inflight_pc_q[31:0], FIFO of 2 entries {pc,inst}, count_q (0..2).
- Reset (async, cpu_rstn=0): pc_q=RESET_PC, inflight_q=0, count_q=0, FIFO pointers 0. Outputs while in reset: inst_req=0, if_valid=0, if_pc=0, if_inst=0.
- Issue: inst_req = cpu_rstn_synced_high && !br_taken && (count_q + inflight_q < 2).
  - On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Otherwise inflight_q<=0.
  - First request is issued in the first cycle after reset deassertion.
- Response: arrives in the cycle where inflight_q=1, as {inflight_pc_q, inst_rdata}.
- Presentation (head):
  - If count_q>0, head = FIFO head entry.
  - Else if inflight_q=1, head = response (bypass, zero added latency).
  - Else empty.
  - if_valid = head present && !br_taken.
- Pop: fire = if_valid && id_allowin. On fire the head is consumed: a FIFO pop if count_q>0, otherwise the bypassed response is consumed and not written.
- Push: a response that is not consumed by bypass is written to the FIFO tail when br_taken=0.
  - Simultaneous push and pop keeps count_q unchanged.
- Overflow is impossible by construction of the issue rule. This is an assertion target: count_q never exceeds 2.
- Latency: request in cycle N, instruction presented in N+1. Sustained throughput is 1 instr/cycle while id_allowin=1.
- Redirect (br_taken=1), which has priority over every other event:
  - pc_q<={br_target[31:2],2'b00}; FIFO cleared; count_q<=0.
  - Any response arriving this cycle is discarded.
  - No request is issued this cycle; inflight_q<=0.
  - if_valid=0 this cycle.
  - The target is requested in N+1 and presented in N+2.
- ID stall (id_allowin=0): head holds stable (pc and inst unchanged) until fired or squashed.
- Reset mid-operation: all state returns to reset values immediately. Any SRAM response after reset is ignored because inflight_q=0.

Decomposition:
- Shared package/defines:
  - RESET_PC default.
  - NOP encoding 32'h0340_0000 (andi r0,r0,0).
  - Fetch-packet field widths (PC 32, INST 32).
- Sub-module fetch_buf: 2-entry FIFO with bypass input, push/pop/flush, count output. The parent holds the PC, issue logic and redirect.

Test Plan:
- Reset release, SRAM returns mem[addr]=addr^32'hA5A5_0000, id_allowin=1 -> inst_addr 0x1C000000,0x1C000004,… one per cycle; if_valid from cycle 2; if_pc sequence matches with no gaps.
- Stream then id_allowin=0 for 4 cycles -> count_q reaches 2; inst_req low; if_pc frozen at 0x1C000008. On release, 0x1C000008, 0x1C00000C and 0x1C000010 arrive back-to-back with none lost or duplicated.
- br_taken=1, br_target=0x1C000100 while FIFO full -> if_valid=0 that cycle; next cycle inst_addr=0x1C000100; following cycle if_pc=0x1C000100; no old-PC instruction ever presented.
- br_taken in the same cycle as a response and id_allowin=1 -> response dropped, no fire, count_q=0.
- br_target=0x1C000102 -> inst_addr 0x1C000100.
- Redirect to 0xFFFFFFFC -> next fetch addresses 0xFFFFFFFC then 0x00000000.
- Assert cpu_rstn=0 asynchronously mid-stall with count_q=2 -> outputs zero immediately; after release, fetch restarts at 0x1C000000.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the LA32R instruction-fetch stage.
// The fetch packet pairs each instruction with its PC as it travels toward ID.
package if_fetch_stage_pkg;

    localparam int          PC_W             = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
    localparam logic [31:0] NOP_INST         = 32'h0340_0000;  // andi r0,r0,0

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: SRAM request/response, redirect from branch
// resolution, and the valid/allowin handshake toward ID.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic              inst_req;
    logic [PC_W-1:0]   inst_addr;
    logic [INST_W-1:0] inst_rdata;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              id_allowin;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;

    modport master (
        output inst_req, inst_addr, if_valid, if_pc, if_inst,
        input  inst_rdata, br_taken, br_target, id_allowin
    );

    modport slave (
        input  inst_req, inst_addr, if_valid, if_pc, if_inst,
        output inst_rdata, br_taken, br_target, id_allowin
    );

endinterface

// File: rtl/if_fetch_stage_fetch_buf.sv
// Two-entry fetch FIFO with a bypass path: an empty buffer presents the
// incoming SRAM response directly so a fetch costs no extra cycle.
module fetch_buf
    import if_fetch_stage_pkg::*;
(
    input  logic       cpu_clk,
    input  logic       cpu_rstn,
    input  logic       flush,
    input  logic       bypass_valid,
    input  fetch_pkt_t bypass_pkt,
    input  logic       pop,
    output logic       head_valid,
    output fetch_pkt_t head_pkt,
    output logic [1:0] count
);

    fetch_pkt_t mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       fifo_nonempty;
    logic       pop_fifo;
    logic       push;

    assign fifo_nonempty = (count_q != 2'd0);
    assign head_valid    = fifo_nonempty || bypass_valid;
    assign head_pkt      = fifo_nonempty ? mem_q[rd_ptr_q] : bypass_pkt;
    assign pop_fifo      = pop && fifo_nonempty && !flush;
    // A response consumed straight off the bypass never occupies a slot.
    assign push          = bypass_valid && !flush && !(pop && !fifo_nonempty);
    assign count         = count_q;

    // NOTE: every state update below is non-blocking so all flops sample pre-edge values.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push)     wr_ptr_q <= !wr_ptr_q;
            if (pop_fifo) rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop_fifo};
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q alone decides which entries are live.
    always_ff @(posedge cpu_clk) begin
        if (push) mem_q[wr_ptr_q] <= bypass_pkt;
    end

    count_max_a: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn) count_q <= 2'd2);

endmodule

// File: rtl/if_fetch_stage.sv
// LA32R instruction-fetch stage: owns the PC, issues 1-cycle-latency SRAM
// reads, and hands {pc, inst} to ID; redirects squash all wrong-path work.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             cpu_clk,
    input  logic             cpu_rstn,
    if_fetch_stage_if.master bus
);

    logic            run_q;
    logic [PC_W-1:0] pc_q;
    logic            inflight_q;
    logic [PC_W-1:0] inflight_pc_q;

    logic [1:0]      count;
    logic [1:0]      occupancy;
    logic            issue;
    logic            head_valid;
    logic            fire;
    fetch_pkt_t      head_pkt;
    fetch_pkt_t      rsp_pkt;

    // Slots already claimed (buffered + in flight) bound how many we may request.
    assign occupancy = count + {1'b0, inflight_q};
    assign issue     = run_q && !bus.br_taken && (occupancy < 2'd2);
    assign rsp_pkt   = '{pc: inflight_pc_q, inst: bus.inst_rdata};
    assign fire      = bus.if_valid && bus.id_allowin;

    assign bus.inst_req  = issue;
    assign bus.inst_addr = pc_q;
    assign bus.if_valid  = head_valid && !bus.br_taken;
    assign bus.if_pc     = bus.if_valid ? head_pkt.pc   : '0;
    assign bus.if_inst   = bus.if_valid ? head_pkt.inst : '0;

    fetch_buf u_fetch_buf (
        .cpu_clk      (cpu_clk),
        .cpu_rstn     (cpu_rstn),
        .flush        (bus.br_taken),
        .bypass_valid (inflight_q),
        .bypass_pkt   (rsp_pkt),
        .pop          (fire),
        .head_valid   (head_valid),
        .head_pkt     (head_pkt),
        .count        (count)
    );

    // run_q keeps requests off until the first edge after reset release.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (bus.br_taken) begin
                pc_q       <= align_pc(bus.br_target);
                inflight_q <= 1'b0;
            end else if (issue) begin
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end else begin
                inflight_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: per-cycle vector table plus an
// in-order scoreboard of requested PCs matched against instructions handed to ID.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [31:0] B = 32'h1C00_0000;

    logic cpu_clk  = 1'b0;
    logic cpu_rstn = 1'b0;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(B)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .bus      (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        alw;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t       vecs[$];
    fetch_pkt_t sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         fires    = 0;
    logic       pend_valid = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic alw, input logic br, input logic [31:0] tgt,
                       input logic req, input logic [31:0] addr,
                       input logic valid, input logic [31:0] pc);
        vecs.push_back('{alw: alw, br: br, tgt: tgt, exp_req: req, exp_addr: addr,
                         exp_valid: valid, exp_pc: pc});
    endtask

    // One clock cycle: SRAM answers last cycle's request, inputs are applied
    // mid-cycle, and the scoreboard pops on handoff and pushes on request.
    task automatic drive_cycle(input logic alw, input logic br, input logic [31:0] tgt);
        fetch_pkt_t pkt;
        @(negedge cpu_clk);
        bus.inst_rdata = pend_valid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        bus.id_allowin = alw;
        bus.br_taken   = br;
        bus.br_target  = tgt;
        #1;
        if (br) begin
            sb.delete();
        end else if (bus.if_valid && alw) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_fire: got pc %h expected no instruction", bus.if_pc);
            end else begin
                pkt = sb.pop_front();
                check("sb_pc", bus.if_pc, pkt.pc);
                check("sb_inst", bus.if_inst, pkt.inst);
                fires++;
            end
        end
        if (bus.inst_req) sb.push_back('{pc: bus.inst_addr, inst: mem_word(bus.inst_addr)});
        pend_valid = bus.inst_req;
        pend_addr  = bus.inst_addr;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   {31'd0, bus.inst_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
        check({tag, "_pc"},    bus.if_pc,   32'd0);
        check({tag, "_inst"},  bus.if_inst, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.inst_rdata = 32'hDEAD_BEEF;
        bus.id_allowin = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;

        //   alw br  tgt            req addr           valid pc
        add(1, 0, 0,               1, B,              0, 0);
        add(1, 0, 0,               1, B + 32'h04,     1, B);
        add(1, 0, 0,               1, B + 32'h08,     1, B + 32'h04);
        add(0, 0, 0,               1, B + 32'h0C,     1, B + 32'h08);
        add(0, 0, 0,               0, B + 32'h10,     1, B + 32'h08);
        add(0, 0, 0,               0, B + 32'h10,     1, B + 32'h08);
        add(0, 0, 0,               0, B + 32'h10,     1, B + 32'h08);
        add(1, 0, 0,               0, B + 32'h10,     1, B + 32'h08);
        add(1, 0, 0,               1, B + 32'h10,     1, B + 32'h0C);
        add(1, 0, 0,               1, B + 32'h14,     1, B + 32'h10);
        add(1, 0, 0,               1, B + 32'h18,     1, B + 32'h14);
        add(0, 0, 0,               1, B + 32'h1C,     1, B + 32'h18);
        add(0, 0, 0,               0, B + 32'h20,     1, B + 32'h18);
        add(0, 1, B + 32'h100,     0, B + 32'h20,     0, 0);
        add(1, 0, 0,               1, B + 32'h100,    0, 0);
        add(1, 0, 0,               1, B + 32'h104,    1, B + 32'h100);
        add(1, 1, B + 32'h102,     0, B + 32'h108,    0, 0);
        add(1, 0, 0,               1, B + 32'h100,    0, 0);
        add(1, 1, 32'hFFFF_FFFC,   0, B + 32'h104,    0, 0);
        add(1, 0, 0,               1, 32'hFFFF_FFFC,  0, 0);
        add(1, 0, 0,               1, 32'h0000_0000,  1, 32'hFFFF_FFFC);
        add(1, 0, 0,               1, 32'h0000_0004,  1, 32'h0000_0000);
        add(0, 0, 0,               1, 32'h0000_0008,  1, 32'h0000_0004);
        add(0, 0, 0,               0, 32'h0000_000C,  1, 32'h0000_0004);
        add(0, 0, 0,               0, 32'h0000_000C,  1, 32'h0000_0004);

        repeat (3) @(negedge cpu_clk);
        #1;
        check_outputs_zero("reset");
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].alw, vecs[i].br, vecs[i].tgt);
            check($sformatf("v%0d_req", i),   {31'd0, bus.inst_req}, {31'd0, vecs[i].exp_req});
            check($sformatf("v%0d_addr", i),  bus.inst_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), {31'd0, bus.if_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_pc", i),    bus.if_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_inst", i),  bus.if_inst,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'd0);
        end

        // Asynchronous reset in the middle of a full-buffer stall.
        drive_cycle(1'b0, 1'b0, 32'd0);
        check("stall_pc", bus.if_pc, 32'h0000_0004);
        #2;
        cpu_rstn = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        sb.delete();
        pend_valid = 1'b0;
        @(negedge cpu_clk);
        #1;
        check_outputs_zero("held_rst");
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;

        drive_cycle(1'b1, 1'b0, 32'd0);
        check("restart_req",   {31'd0, bus.inst_req}, 32'd1);
        check("restart_addr",  bus.inst_addr, B);
        check("restart_valid", {31'd0, bus.if_valid}, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'd0);
        check("restart_pc",    bus.if_pc, B);
        check("restart_inst",  bus.if_inst, mem_word(B));
        check("restart_addr2", bus.inst_addr, B + 32'h04);
        repeat (3) drive_cycle(1'b1, 1'b0, 32'd0);

        check("fire_count", fires, 32'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
